// File: rtl/sprite_pkg.sv
// Shared constants, patch ids, ROM payload and FSM encoding for the sprite writer.
package sprite_pkg;

    localparam int unsigned WIDTH      = 128;
    localparam int unsigned HEIGHT     = 128;
    localparam int unsigned PIXEL_SIZE = 16;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned LOG2_W     = $clog2(WIDTH);
    localparam int unsigned COORD_W    = 7;
    localparam int unsigned DIM_W      = 3;
    localparam int unsigned MASK_W     = 8;
    localparam int unsigned ID_W       = 3;

    // RGB565 palette
    localparam logic [PIXEL_SIZE-1:0] SKIN_C  = 16'hff14;
    localparam logic [PIXEL_SIZE-1:0] BLACK_C = 16'h0000;
    localparam logic [PIXEL_SIZE-1:0] CHEEK_C = 16'h4dac;
    localparam logic [PIXEL_SIZE-1:0] SWEAT_C = 16'h3ef8;

    typedef enum logic [1:0] {
        EYE_OPEN   = 2'd0,
        EYE_CLOSED = 2'd1,
        CHEEK      = 2'd2,
        SWEAT      = 2'd3
    } patch_id_t;

    // Geometry and colours of one patch as delivered by the ROM
    typedef struct packed {
        logic [COORD_W-1:0]    x;
        logic [COORD_W-1:0]    y;
        logic [DIM_W-1:0]      w;
        logic [DIM_W-1:0]      h;
        logic [PIXEL_SIZE-1:0] fg;
        logic [PIXEL_SIZE-1:0] bg;
        logic                  bg_opaque;
    } patch_geom_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/sprite_patch_writer_patch_rom.sv
// Combinational patch table: geometry, colours and one left-aligned mask row.
module patch_rom
    import sprite_pkg::*;
(
    input  logic [ID_W-1:0]   id,
    input  logic [DIM_W-1:0]  row,
    output patch_geom_t       geom,
    output logic [MASK_W-1:0] mask,
    output logic              valid
);

    // Table lookup; mask bit 7 is the leftmost pixel, rows past h read as zero
    always_comb begin
        geom  = '0;
        mask  = '0;
        valid = 1'b0;
        case (id)
            {1'b0, EYE_OPEN}: begin
                valid = 1'b1;
                geom  = '{x: 7'd76, y: 7'd57, w: 3'd6, h: 3'd3,
                          fg: BLACK_C, bg: SKIN_C, bg_opaque: 1'b1};
                case (row)
                    3'd0:    mask = 8'b1000_0100;
                    3'd1:    mask = 8'b0100_1000;
                    3'd2:    mask = 8'b0011_0000;
                    default: mask = '0;
                endcase
            end
            {1'b0, EYE_CLOSED}: begin
                valid = 1'b1;
                geom  = '{x: 7'd76, y: 7'd57, w: 3'd6, h: 3'd3,
                          fg: BLACK_C, bg: SKIN_C, bg_opaque: 1'b1};
                case (row)
                    3'd0:    mask = 8'b0111_1000;
                    3'd1:    mask = 8'b1111_1100;
                    3'd2:    mask = 8'b0111_1000;
                    default: mask = '0;
                endcase
            end
            {1'b0, CHEEK}: begin
                valid = 1'b1;
                geom  = '{x: 7'd82, y: 7'd53, w: 3'd4, h: 3'd3,
                          fg: CHEEK_C, bg: BLACK_C, bg_opaque: 1'b0};
                case (row)
                    3'd0, 3'd1, 3'd2: mask = 8'b1111_0000;
                    default:          mask = '0;
                endcase
            end
            {1'b0, SWEAT}: begin
                valid = 1'b1;
                geom  = '{x: 7'd53, y: 7'd44, w: 3'd6, h: 3'd4,
                          fg: SWEAT_C, bg: BLACK_C, bg_opaque: 1'b0};
                case (row)
                    3'd0:    mask = 8'b0011_1000;
                    3'd1:    mask = 8'b1111_1100;
                    3'd2:    mask = 8'b1111_1100;
                    3'd3:    mask = 8'b0011_1000;
                    default: mask = '0;
                endcase
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sprite_patch_writer.sv
// Stamps one facial-feature patch into the sprite frame buffer per request,
// stalling pixel writes while the reader streams a frame.
module sprite_patch_writer
    import sprite_pkg::*;
(
    input  logic                  clk_input_data,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ID_W-1:0]       patch_sel,
    input  logic                  frame_busy,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PIXEL_SIZE-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    logic [1:0]            state, state_n;
    logic [1:0]            sel_q, sel_n;
    patch_geom_t           geom_q, geom_n;
    logic [DIM_W-1:0]      col_q, col_n;
    logic [DIM_W-1:0]      row_q, row_n;
    logic                  wr_en_n;
    logic [ADDR_W-1:0]     wr_addr_n;
    logic [PIXEL_SIZE-1:0] wr_data_n;
    logic                  busy_n, done_n, err_n;

    logic [ID_W-1:0]       rom_id;
    patch_geom_t           rom_geom;
    logic [MASK_W-1:0]     rom_mask;
    logic                  rom_valid;

    logic                  pix_on;
    logic [COORD_W-1:0]    pix_x, pix_y;

    // In IDLE the ROM looks at the incoming id so validity is known at accept
    assign rom_id = (state == ST_IDLE) ? patch_sel : {1'b0, sel_q};

    patch_rom u_rom (
        .id    (rom_id),
        .row   (row_q),
        .geom  (rom_geom),
        .mask  (rom_mask),
        .valid (rom_valid)
    );

    // Current pixel: mask bit and frame coordinates
    always_comb begin
        pix_on = rom_mask[3'(3'd7 - col_q)];
        pix_x  = geom_q.x + COORD_W'(col_q);
        pix_y  = geom_q.y + COORD_W'(row_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        sel_n     = sel_q;
        geom_n    = geom_q;
        col_n     = col_q;
        row_n     = row_q;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    sel_n = patch_sel[1:0];
                    err_n = 1'b0;
                    col_n = '0;
                    row_n = '0;
                    if (rom_valid) begin
                        busy_n  = 1'b1;
                        state_n = ST_LOAD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_FINISH;
                    end
                end
            end
            ST_LOAD: begin
                geom_n  = rom_geom;
                col_n   = '0;
                row_n   = '0;
                busy_n  = 1'b1;
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                // A busy frame suppresses this pixel; it is presented again later
                if (!frame_busy) begin
                    wr_addr_n = (ADDR_W'(pix_y) << LOG2_W) + ADDR_W'(pix_x);
                    wr_data_n = pix_on ? geom_q.fg : geom_q.bg;
                    wr_en_n   = pix_on | geom_q.bg_opaque;
                    if (col_q == geom_q.w - 3'd1) begin
                        col_n = '0;
                        if (row_q == geom_q.h - 3'd1) begin
                            state_n = ST_FINISH;
                        end else begin
                            row_n = row_q + 3'd1;
                        end
                    end else begin
                        col_n = col_q + 3'd1;
                    end
                end
            end
            ST_FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk_input_data) begin
        if (!rst) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            geom_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            sel_q   <= sel_n;
            geom_q  <= geom_n;
            col_q   <= col_n;
            row_q   <= row_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_sprite_patch_writer.sv
// Directed bench for sprite_patch_writer: write sequences, timing, stalls,
// invalid ids, reset mid-patch and ignored starts.
module tb_sprite_patch_writer;

    logic        clk_input_data = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  patch_sel;
    logic        frame_busy;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    sprite_patch_writer dut (
        .clk_input_data (clk_input_data),
        .rst            (rst),
        .start          (start),
        .patch_sel      (patch_sel),
        .frame_busy     (frame_busy),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk_input_data = ~clk_input_data;

    int cyc = 0;
    always @(posedge clk_input_data) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    // Reference patch table
    int          px [4] = '{76, 76, 82, 53};
    int          py [4] = '{57, 57, 53, 44};
    int          pw [4] = '{6, 6, 4, 6};
    int          ph [4] = '{3, 3, 3, 4};
    logic [15:0] pfg[4] = '{16'h0000, 16'h0000, 16'h4dac, 16'h3ef8};
    logic [15:0] pbg[4] = '{16'hff14, 16'hff14, 16'h0000, 16'h0000};
    bit          pop[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int          pm [4][4] = '{'{6'b100001, 6'b010010, 6'b001100, 0},
                               '{6'b011110, 6'b111111, 6'b011110, 0},
                               '{4'b1111, 4'b1111, 4'b1111, 0},
                               '{6'b001110, 6'b111111, 6'b111111, 6'b001110}};

    logic [13:0] ga[$];
    logic [15:0] gd[$];
    int          gc[$];
    logic [13:0] ea[$];
    logic [15:0] ed[$];
    int          s_cyc, done_cyc, done_cnt, stall_wr;
    logic        busy_at_done, err_at_done, busy_mid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic build_exp(input int sel);
        ea.delete();
        ed.delete();
        for (int r = 0; r < ph[sel]; r++) begin
            for (int c = 0; c < pw[sel]; c++) begin
                if (((pm[sel][r] >> (pw[sel] - 1 - c)) & 1) != 0) begin
                    ea.push_back(14'((py[sel] + r) * 128 + px[sel] + c));
                    ed.push_back(pfg[sel]);
                end else if (pop[sel]) begin
                    ea.push_back(14'((py[sel] + r) * 128 + px[sel] + c));
                    ed.push_back(pbg[sel]);
                end
            end
        end
    endtask

    task automatic run_patch(input logic [2:0] sel, input int stall_from, input int stall_len,
                             input int extra_start, input int budget);
        logic fb_sampled;
        ga.delete();
        gd.delete();
        gc.delete();
        done_cyc     = -1;
        done_cnt     = 0;
        stall_wr     = 0;
        busy_at_done = 1'b1;
        err_at_done  = 1'b0;
        busy_mid     = 1'b0;
        fb_sampled   = 1'b0;
        @(negedge clk_input_data);
        patch_sel = sel;
        start     = 1'b1;
        s_cyc     = cyc + 1;
        @(negedge clk_input_data);
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wr_en) begin
                ga.push_back(wr_addr);
                gd.push_back(wr_data);
                gc.push_back(cyc);
                if (fb_sampled) stall_wr++;
            end
            if (cyc == s_cyc + 3) busy_mid = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = busy;
                    err_at_done  = err;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            frame_busy = (stall_len > 0) && (cyc + 1 >= s_cyc + stall_from) &&
                         (cyc + 1 < s_cyc + stall_from + stall_len);
            fb_sampled = frame_busy;
            start      = (extra_start > 0) && (cyc + 1 == s_cyc + extra_start);
            @(negedge clk_input_data);
        end
        frame_busy = 1'b0;
        start      = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, 32'(ga.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            if (i < ga.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), 32'(ga[i]), 32'(ea[i]));
                chk($sformatf("%s_data%0d", tag, i), 32'(gd[i]), 32'(ed[i]));
            end
        end
    endtask

    initial begin
        int hits;
        rst        = 1'b0;
        start      = 1'b0;
        frame_busy = 1'b0;
        patch_sel  = 3'd0;
        repeat (3) @(negedge clk_input_data);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        rst = 1'b1;

        // Eye open, with a stray start mid-patch that must be ignored
        run_patch(3'd0, 0, 0, 8, 60);
        build_exp(0);
        check_seq("eye_open");
        if (ga.size() > 0) begin
            chk("eo_first_cyc", 32'(gc[0]), 32'(s_cyc + 2));
            chk("eo_first_addr", 32'(ga[0]), 32'd7372);
            chk("eo_first_data", 32'(gd[0]), 32'h0000);
            chk("eo_last_addr", 32'(ga[ga.size()-1]), 32'd7633);
            chk("eo_last_data", 32'(gd[gd.size()-1]), 32'hff14);
            chk("eo_done_after_last", 32'(done_cyc), 32'(gc[gc.size()-1] + 1));
        end
        chk("eo_done_cyc", 32'(done_cyc), 32'(s_cyc + 20));
        chk("eo_busy_mid", 32'(busy_mid), 32'd1);
        chk("eo_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("eo_single_done", 32'(done_cnt), 32'd1);

        // Cheek: transparent background, fully set mask
        run_patch(3'd2, 0, 0, 0, 60);
        build_exp(2);
        check_seq("cheek");
        chk("ck_done_cyc", 32'(done_cyc - s_cyc), 32'd14);

        // Sweat: transparent pixels are skipped but still cost a cycle
        run_patch(3'd3, 0, 0, 0, 60);
        build_exp(3);
        check_seq("sweat");
        hits = 0;
        foreach (ga[i]) if (ga[i] == 14'd5685) hits++;
        chk("sw_5685_unwritten", 32'(hits), 32'd0);
        chk("sw_done_cyc", 32'(done_cyc), 32'(s_cyc + 26));

        // Eye closed with a 10-cycle stall starting at the 5th pixel
        run_patch(3'd1, 6, 10, 0, 80);
        build_exp(1);
        check_seq("eye_closed");
        chk("ec_stall_writes", 32'(stall_wr), 32'd0);
        hits = 0;
        foreach (ga[i]) if (ga[i] == 14'd7500) hits++;
        chk("ec_7500_once", 32'(hits), 32'd1);
        for (int k = 0; k < 18; k++) begin
            if (k < gc.size())
                chk($sformatf("ec_cyc%0d", k), 32'(gc[k]), 32'(s_cyc + 2 + k + ((k >= 4) ? 10 : 0)));
        end
        chk("ec_done_cyc", 32'(done_cyc), 32'(s_cyc + 30));

        // Invalid id: no writes, sticky err, then cleared by a valid start
        run_patch(3'd5, 0, 0, 0, 20);
        chk("inv_writes", 32'(ga.size()), 32'd0);
        chk("inv_done_cyc", 32'(done_cyc), 32'(s_cyc + 1));
        chk("inv_err_at_done", 32'(err_at_done), 32'd1);
        repeat (3) @(negedge clk_input_data);
        chk("inv_err_sticky", 32'(err), 32'd1);
        run_patch(3'd2, 0, 0, 0, 60);
        chk("inv_err_cleared", 32'(err), 32'd0);

        // Reset mid-patch abandons the patch
        @(negedge clk_input_data);
        patch_sel = 3'd0;
        start     = 1'b1;
        @(negedge clk_input_data);
        start = 1'b0;
        repeat (4) @(negedge clk_input_data);
        chk("mid_wr_active", 32'(wr_en), 32'd1);
        rst = 1'b0;
        @(negedge clk_input_data);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk_input_data);
        rst = 1'b1;
        repeat (3) @(negedge clk_input_data);
        chk("post_rst_idle", 32'(wr_en), 32'd0);
        run_patch(3'd0, 0, 0, 0, 60);
        build_exp(0);
        check_seq("restart");
        if (ga.size() > 0) chk("restart_first", 32'(ga[0]), 32'd7372);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_patch_writer.md
Name: sprite_patch_writer

Overview:
Write-side companion to the pixel-stream reader. It edits the 128x128 RGB565 sprite frame buffer by stamping small facial-feature patches (eyes, cheeks, sweat) at fixed coordinates, so the pixel reader streams the updated sprite to the ILI9341 controller. A state-machine layer issues one patch request at a time. Writes are held off while a frame is being streamed, which prevents tearing.

Parameters:
WIDTH, 128, frame width in pixels (power of two)
HEIGHT, 128, frame height in pixels
PIXEL_SIZE, 16, bits per pixel (RGB565)
ADDR_W, 14, frame-buffer address width, equal to $clog2(WIDTH*HEIGHT)

Ports:
clk_input_data  in  1  pixel-domain clock (same clock as the frame-buffer reader)
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle request; accepted only in IDLE
patch_sel  in  3  patch id; 0..3 are valid, 4..7 are invalid
frame_busy  in  1  high while a frame is being streamed; stalls writes
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  write address, equal to y*WIDTH+x
wr_data  out  PIXEL_SIZE  pixel written
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the patch completes
err  out  1  sticky flag for an invalid patch_sel; cleared by the next accepted start

Behaviour:
- Reset (rst=0 at a clk_input_data edge):
  - state goes to IDLE.
  - wr_en, busy, done and err all go to 0.
  - wr_addr and wr_data go to 0.
  - This applies mid-patch as well: the patch is abandoned with no further writes and the buffer is left partially stamped.
- Patch table (x, y, w, h, fg, bg, mask rows MSB = leftmost pixel):
  - 0 EYE_OPEN: 76, 57, 6, 3; fg 16'h0000; bg 16'hff14 (opaque); rows 100001, 010010, 001100.
  - 1 EYE_CLOSED: 76, 57, 6, 3; fg 16'h0000; bg 16'hff14 (opaque); rows 011110, 111111, 011110.
  - 2 CHEEK: 82, 53, 4, 3; fg 16'h4dac; bg transparent; rows 1111 x3.
  - 3 SWEAT: 53, 44, 6, 4; fg 16'h3ef8; bg transparent; rows 001110, 111111, 111111, 001110.
- FSM states: IDLE -> LOAD -> WRITE -> FINISH -> IDLE.
  - IDLE: on start=1, latch patch_sel and clear err.
    - Valid id: go to LOAD.
    - Invalid id: go to FINISH with err=1 and no writes.
  - LOAD: one cycle. Fetch geometry and colours; set col=0, row=0; busy=1.
  - WRITE: while frame_busy=1, stall with counters frozen and wr_en=0. Otherwise process one pixel per cycle:
    - mask bit = 1: wr_en=1, wr_data=fg.
    - mask bit = 0 and bg opaque: wr_en=1, wr_data=bg.
    - mask bit = 0 and bg transparent: wr_en=0, but the position still advances.
    - wr_addr = ((y+row) << log2(WIDTH)) + (x+col). wr_addr, wr_data and wr_en are registered and valid in the same cycle.
    - col wraps to 0 at w-1 and row increments. After the pixel (w-1, h-1), go to FINISH.
  - FINISH: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- Latency: first write appears 2 cycles after the start edge when frame_busy=0. Total cycles = 2 + w*h + stall cycles + 1.
- start while busy is ignored and never queued. start in the FINISH cycle is also ignored.
- frame_busy rising mid-patch: the pixel being presented in that cycle is suppressed (not written) and is retried once frame_busy falls. No pixel is skipped or duplicated.
- Address arithmetic is ADDR_W-bit unsigned. All table entries lie in frame, so no wrap check is needed. Adder width is y+row <= 127 (7 bits) and x+col <= 127 (7 bits).

Decomposition:
- Shared package sprite_pkg:
  - RGB565 colour constants: SKIN ff14, BLACK 0000, CHEEK 4dac, SWEAT 3ef8.
  - Patch id enum: EYE_OPEN, EYE_CLOSED, CHEEK, SWEAT.
  - WIDTH/HEIGHT constants.
  - FSM state encoding.
- Sub-module patch_rom (combinational):
  - Inputs: patch id, row.
  - Outputs: x, y, w, h, fg, bg, bg_opaque, an 8-bit mask row, and a valid flag.
  - Keeps the table out of the FSM.

Test Plan:
1. Reset, then patch_sel=0, start, frame_busy=0 -> 2 cycles later wr_addr 7372 with data 0000. Then 18 consecutive writes; the last is addr 7633 with data ff14. done pulses the cycle after the last write.
2. patch_sel=2, start -> exactly 12 writes, all data 4dac; addresses 6866-6869, 6994-6997, 7122-7125; done after 15 cycles total.
3. patch_sel=3 -> 18 writes, data 3ef8; first addr 5687; transparent pixels (e.g. 5685) are never written; the last write is addr 6073.
4. patch_sel=1 with frame_busy held high for 10 cycles from the 5th pixel onward -> wr_en=0 during the stall; addr 7500 is written exactly once after release; the sequence completes with no gaps.
5. start with patch_sel=5 -> no wr_en; err=1; done pulse 1 cycle after start. A following valid start clears err.
6. rst=0 mid-patch 0 -> wr_en, busy and done are 0 at that edge. A new start after reset restarts from addr 7372. A start asserted while busy is ignored, with no second done.
